// File: rtl/stream_pack_ctrl.sv
// stream_pack_ctrl: frame controller for the lane-compaction mux.
// Tracks packing-register occupancy through a delayed per-beat item count,
// presents full words downstream, drains the mux at end of frame and emits
// the trailing partial word with tlast and the frame byte count.
module stream_pack_ctrl #(
  parameter int NUM_DATA          = 8,
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int OUTPUT_DATA_WIDTH = 64,
  parameter int MUX_LATENCY       = NUM_DATA
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            s_valid_i,
  input  logic [NUM_DATA-1:0]                             s_valid_mask_i,
  input  logic                                            s_last_i,
  output logic                                            s_ready_o,
  output logic [NUM_DATA-1:0]                             mux_valid_o,
  output logic                                            mux_ready_o,
  output logic                                            m_valid_o,
  input  logic                                            m_ready_i,
  output logic                                            m_last_o,
  output logic [OUTPUT_DATA_WIDTH/INPUT_DATA_WIDTH-1:0]   m_keep_o,
  output logic                                            done_o,
  output logic [31:0]                                     byte_count_o
);

  localparam int BPW   = OUTPUT_DATA_WIDTH / INPUT_DATA_WIDTH;
  localparam int OCC_W = $clog2(BPW + NUM_DATA + 1);
  localparam int CNT_W = $clog2(NUM_DATA + 1);
  localparam int DRN_W = $clog2(MUX_LATENCY + 1);
  localparam logic [OCC_W-1:0] BPW_O      = OCC_W'(BPW);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(MUX_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

  state_t               state_q, state_d;
  logic [OCC_W-1:0]     occ_q, occ_d, occ_sub;
  logic [CNT_W-1:0]     dly_q [MUX_LATENCY];
  logic [DRN_W-1:0]     drn_q;
  logic [31:0]          bc_q;
  logic                 rdy_en_q;
  logic                 accept, advance, word_xfer;

  function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_DATA-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_DATA; i++) c = c + CNT_W'(m[i]);
    return c;
  endfunction

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = s_last_i ? DRAIN : RUN;
      RUN:   if (accept && s_last_i) state_d = DRAIN;
      DRAIN: if (advance && drn_q == DRAIN_LAST) state_d = FLUSH;
      FLUSH: if (occ_q == '0 || (word_xfer && m_last_o)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: word valid/keep/last from occupancy, handshakes, done pulse
  always_comb begin
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    m_keep_o  = '0;
    if (state_q == FLUSH) begin
      m_valid_o = (occ_q != '0);
      if (occ_q >= BPW_O) begin
        m_keep_o = '1;
        m_last_o = (occ_q == BPW_O);
      end else if (m_valid_o) begin
        for (int i = 0; i < BPW; i++) m_keep_o[i] = (OCC_W'(i) < occ_q);
        m_last_o = 1'b1;
      end
    end else begin
      m_valid_o = (occ_q >= BPW_O);
      if (m_valid_o) m_keep_o = '1;
    end
    mux_ready_o = !(m_valid_o && !m_ready_i);
    advance     = mux_ready_o;
    word_xfer   = m_valid_o && m_ready_i;
    s_ready_o   = rdy_en_q && mux_ready_o && (state_q == IDLE || state_q == RUN);
    accept      = s_valid_i && s_ready_o;
    mux_valid_o = accept ? s_valid_mask_i : '0;
    done_o      = (state_q == FLUSH) && (occ_q == '0 || (word_xfer && m_last_o));
    byte_count_o = bc_q;
  end

  // Occupancy next value; a partial final word empties the register
  always_comb begin
    occ_sub = (occ_q >= BPW_O) ? BPW_O : occ_q;
    occ_d   = occ_q;
    if (advance)   occ_d = occ_d + OCC_W'(dly_q[MUX_LATENCY-1]);
    if (word_xfer) occ_d = occ_d - occ_sub;
  end

  // Count delay line, occupancy, drain counter, byte counter, ready enable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MUX_LATENCY; i++) dly_q[i] <= '0;
      occ_q    <= '0;
      drn_q    <= '0;
      bc_q     <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      occ_q    <= occ_d;
      if (advance) begin
        dly_q[0] <= popcnt(mux_valid_o);
        for (int i = 1; i < MUX_LATENCY; i++) dly_q[i] <= dly_q[i-1];
      end
      if (state_q != DRAIN)  drn_q <= '0;
      else if (advance)      drn_q <= drn_q + 1'b1;
      if (accept) begin
        if (state_q == IDLE) bc_q <= 32'(popcnt(s_valid_mask_i));
        else                 bc_q <= bc_q + 32'(popcnt(s_valid_mask_i));
      end
    end
  end

endmodule

// File: tb/tb_stream_pack_ctrl.sv
// Scoreboard bench for stream_pack_ctrl: expected words and byte counts are
// queued when a frame is driven and matched as the DUT emits them.
module tb_stream_pack_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        s_valid_i = 1'b0;
  logic [7:0]  s_valid_mask_i = '0;
  logic        s_last_i = 1'b0;
  logic        s_ready_o;
  logic [7:0]  mux_valid_o;
  logic        mux_ready_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;
  logic        m_last_o;
  logic [7:0]  m_keep_o;
  logic        done_o;
  logic [31:0] byte_count_o;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic prev_done = 1'b0;
  logic [8:0]  word_q [$];
  logic [31:0] bc_q [$];

  always #5 clk = ~clk;

  stream_pack_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .s_valid_i(s_valid_i),
    .s_valid_mask_i(s_valid_mask_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .mux_valid_o(mux_valid_o), .mux_ready_o(mux_ready_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_last_o(m_last_o), .m_keep_o(m_keep_o),
    .done_o(done_o), .byte_count_o(byte_count_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pop expectations on word transfers and done pulses
  always @(negedge clk) begin
    if (rst_ni) begin
      if (m_valid_o && m_ready_i) begin
        if (word_q.size() == 0) check_eq("word_unexpected", 32'd1, 32'd0);
        else begin
          logic [8:0] e;
          e = word_q.pop_front();
          check_eq("word_keep", {24'd0, m_keep_o}, {24'd0, e[7:0]});
          check_eq("word_last", {31'd0, m_last_o}, {31'd0, e[8]});
        end
      end
      if (done_o) begin
        done_cnt++;
        if (prev_done) check_eq("done_twice", 32'd1, 32'd0);
        if (bc_q.size() == 0) check_eq("done_unexpected", 32'd1, 32'd0);
        else check_eq("byte_count", byte_count_o, bc_q.pop_front());
      end
      prev_done = done_o;
    end else prev_done = 1'b0;
  end

  // Model the frame's words, queue them, then drive its beats
  task automatic send_frame(input logic [7:0] m[$]);
    int total, nfull, rem, guard;
    logic acc;
    total = 0;
    foreach (m[i]) total += $countones(m[i]);
    nfull = total / 8;
    rem   = total % 8;
    for (int i = 0; i < nfull; i++)
      word_q.push_back({(rem == 0 && i == nfull - 1), 8'hFF});
    if (rem != 0) word_q.push_back({1'b1, 8'((1 << rem) - 1)});
    bc_q.push_back(32'(total));
    exp_done++;
    foreach (m[i]) begin
      s_valid_i = 1'b1;
      s_valid_mask_i = m[i];
      s_last_i = (i == m.size() - 1);
      guard = 0;
      do begin
        @(negedge clk);
        acc = s_ready_o;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 1000);
      if (!acc) check_eq("beat_accept_timeout", 32'd0, 32'd1);
    end
    s_valid_i = 1'b0;
    s_valid_mask_i = '0;
    s_last_i = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (done_cnt < exp_done && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check_eq("done_seen", 32'(done_cnt), 32'(exp_done));
  endtask

  initial begin
    logic [7:0] fr[$];
    bit stop;
    int base;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_s_ready",   {31'd0, s_ready_o},   32'd0);
    check_eq("rst_m_valid",   {31'd0, m_valid_o},   32'd0);
    check_eq("rst_m_last",    {31'd0, m_last_o},    32'd0);
    check_eq("rst_done",      {31'd0, done_o},      32'd0);
    check_eq("rst_mux_valid", {24'd0, mux_valid_o}, 32'd0);
    check_eq("rst_keep",      {24'd0, m_keep_o},    32'd0);
    check_eq("rst_byte_cnt",  byte_count_o,         32'd0);
    check_eq("rst_mux_ready", {31'd0, mux_ready_o}, 32'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check_eq("rdy_before_edge", {31'd0, s_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("rdy_after_edge", {31'd0, s_ready_o}, 32'd1);

    // Full lanes
    fr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_frame(fr);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    check_eq("byte_count_hold", byte_count_o, 32'd32);

    // Partial final word
    fr = '{8'h07, 8'h07, 8'h07};
    send_frame(fr);
    wait_done();

    // Backpressure during RUN
    m_ready_i = 1'b0;
    fr = '{12{8'hFF}};
    fork
      send_frame(fr);
      begin
        int g;
        g = 0;
        do begin @(negedge clk); g++; end while (!m_valid_o && g < 200);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check_eq("stall_mux_ready", {31'd0, mux_ready_o}, 32'd0);
          check_eq("stall_s_ready",   {31'd0, s_ready_o},   32'd0);
          check_eq("stall_m_valid",   {31'd0, m_valid_o},   32'd1);
        end
        @(posedge clk);
        #1;
        m_ready_i = 1'b1;
      end
    join
    wait_done();

    // Empty frame
    fr = '{8'h00};
    send_frame(fr);
    wait_done();

    // Random masks with random downstream readiness
    fr = {};
    for (int i = 0; i < 6; i++) fr.push_back(8'($urandom));
    stop = 0;
    fork
      begin
        send_frame(fr);
        wait_done();
        stop = 1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          m_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready_i = 1'b1;

    // Reset during DRAIN
    fr = '{8'hFF, 8'hFF, 8'hFF};
    send_frame(fr);
    repeat (3) @(posedge clk);
    #1;
    base = done_cnt;
    rst_ni = 1'b0;
    #1;
    check_eq("midrst_m_valid",   {31'd0, m_valid_o},   32'd0);
    check_eq("midrst_done",      {31'd0, done_o},      32'd0);
    check_eq("midrst_occ",       32'(dut.occ_q),       32'd0);
    check_eq("midrst_mux_ready", {31'd0, mux_ready_o}, 32'd1);
    word_q.delete();
    bc_q.delete();
    exp_done = base;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_no_done", 32'(done_cnt), 32'(base));
    fr = '{8'hFF};
    send_frame(fr);
    wait_done();

    repeat (5) @(posedge clk);
    check_eq("sb_words_left", 32'(word_q.size()), 32'd0);
    check_eq("sb_counts_left", 32'(bc_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
